// File: rtl/alu_pkg.sv
// Shared widths, opcodes, state codes and instruction layout for the ALU sequencer.
package alu_pkg;

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned REG_N   = 4;
  localparam int unsigned REG_AW  = 2;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned INSTR_W = 12;

  // Instruction field positions
  localparam int unsigned OP_MSB  = 11;
  localparam int unsigned OP_LSB  = 9;
  localparam int unsigned RD_MSB  = 8;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RS1_MSB = 6;
  localparam int unsigned RS1_LSB = 5;
  localparam int unsigned RS2_MSB = 4;
  localparam int unsigned RS2_LSB = 3;
  localparam int unsigned IMM_MSB = 6;
  localparam int unsigned IMM_LSB = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b011;
  localparam logic [OP_W-1:0] OP_NOT = 3'b100;
  localparam logic [OP_W-1:0] OP_LDI = 3'b101;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t EXEC = 2'd1;
  localparam state_t WB   = 2'd2;

  // Field layout matches the bit positions above; LDI immediate is {rs1, rs2}
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [2:0]        rsvd;
  } instr_t;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return (op <= OP_LDI);
  endfunction

endpackage

// File: rtl/alu4bit.sv
// Combinational 4-bit ALU for AND/OR/ADD/SUB/NOT; other opcodes yield zero.
module alu4bit
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y_c
);

  // Operation select; arithmetic wraps modulo 16
  always_comb begin
    y_c = '0;
    case (op)
      OP_AND:  y_c = a & b;
      OP_OR:   y_c = a | b;
      OP_ADD:  y_c = DATA_W'(a + b);
      OP_SUB:  y_c = DATA_W'(a - b);
      OP_NOT:  y_c = ~a;
      default: y_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Three-cycle (IDLE/EXEC/WB) instruction sequencer around alu4bit with a 4x4 register file.
// Optional macro ALU_SEQ_DBG_EN adds a combinational register read port (dbg_addr/dbg_data).
module alu_sequencer
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  output logic               instr_ready,
  output logic               done,
  output logic [REG_AW-1:0]  wb_rd,
  output logic [DATA_W-1:0]  wb_data,
  output logic               zero_flag,
  output logic               err
`ifdef ALU_SEQ_DBG_EN
  ,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
`endif
);

  state_t            state;
  state_t            state_nxt;
  instr_t            instr_q;
  logic [DATA_W-1:0] regs [REG_N];
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] exec_res;
  logic              unused_rsvd;

  assign unused_rsvd = ^instr_q.rsvd;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; ready depends on state only
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = EXEC;
      end
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the instruction on the handshake; later changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          instr_q <= '0;
    else if (state == IDLE && instr_valid) instr_q <= instr_t'(instr);
  end

  alu4bit u_alu (
    .op  (instr_q.op),
    .a   (regs[instr_q.rs1]),
    .b   (regs[instr_q.rs2]),
    .y_c (alu_y)
  );

  // LDI and illegal opcodes bypass the ALU
  always_comb begin
    exec_res = alu_y;
    if (instr_q.op == OP_LDI)       exec_res = {instr_q.rs1, instr_q.rs2};
    else if (!is_legal(instr_q.op)) exec_res = '0;
  end

  // Register the EXEC result so done/err/wb_* are valid throughout WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done    <= 1'b0;
      err     <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == EXEC) begin
        done    <= 1'b1;
        err     <= !is_legal(instr_q.op);
        wb_rd   <= instr_q.rd;
        wb_data <= exec_res;
      end
    end
  end

  // Commit to the register file and zero flag at the end of WB (legal ops only)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_N; i++) regs[i] <= '0;
      zero_flag <= 1'b0;
    end else if (state == WB && !err) begin
      regs[wb_rd] <= wb_data;
      zero_flag   <= (wb_data == '0);
    end
  end

`ifdef ALU_SEQ_DBG_EN
  assign dbg_data = regs[dbg_addr];
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized and directed bench for alu_sequencer against a transaction-level model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [11:0] instr = '0;
  logic        instr_ready;
  logic        done;
  logic [1:0]  wb_rd;
  logic [3:0]  wb_data;
  logic        zero_flag;
  logic        err;
`ifdef ALU_SEQ_DBG_EN
  logic [1:0]  dbg_addr = '0;
  logic [3:0]  dbg_data;
`endif

  int n_vec = 0;
  int n_bad = 0;

  alu_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .done        (done),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .zero_flag   (zero_flag),
    .err         (err)
`ifdef ALU_SEQ_DBG_EN
    ,
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result of one instruction; -1 marks an illegal opcode
  function automatic int ref_result(input logic [11:0] i, input int a, input int b);
    case (int'(i[11:9]))
      0:       return a & b;
      1:       return a | b;
      2:       return (a + b) % 16;
      3:       return (a - b + 16) % 16;
      4:       return 15 - a;
      5:       return int'(i[6:3]);
      default: return -1;
    endcase
  endfunction

  function automatic logic [11:0] mk(input int op, input int rd, input int rs1, input int rs2);
    return {3'(op), 2'(rd), 2'(rs1), 2'(rs2), 3'b000};
  endfunction

  // Model: an accepted instruction retires two cycles later; age counts cycles since accept
  int m_regs [4];
  int m_zero = 0;
  int m_age  = 0;
  int m_rd   = 0;
  int m_res  = 0;
  int e_rd   = 0;
  int e_data = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_regs[i] <= 0;
      m_zero <= 0; m_age <= 0; m_rd <= 0; m_res <= 0; e_rd <= 0; e_data <= 0;
    end else if (m_age == 2) begin
      if (m_res >= 0) begin
        m_regs[m_rd] <= m_res;
        m_zero       <= int'(m_res == 0);
      end
      m_age <= 0;
    end else if (m_age == 1) begin
      m_age  <= 2;
      e_rd   <= m_rd;
      e_data <= (m_res < 0) ? 0 : m_res;
    end else if (instr_valid) begin
      m_res <= ref_result(instr, m_regs[instr[6:5]], m_regs[instr[4:3]]);
      m_rd  <= int'(instr[8:7]);
      m_age <= 1;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("instr_ready", int'(instr_ready), int'(m_age == 0));
      chk("done", int'(done), int'(m_age == 2));
      chk("err", int'(err), int'(m_age == 2 && m_res < 0));
      chk("wb_rd", int'(wb_rd), e_rd);
      chk("wb_data", int'(wb_data), e_data);
      chk("zero_flag", int'(zero_flag), m_zero);
`ifdef ALU_SEQ_DBG_EN
      chk("dbg_data", int'(dbg_data), m_regs[dbg_addr]);
`endif
    end
  end

  // Issue one instruction and sample the WB cycle, then zero_flag one cycle later
  task automatic run(input logic [11:0] i, output int d, output int r, output int e,
                     output int dn, output int z);
    bit got = 1'b0;
    d = 0; r = 0; e = 0; dn = 0; z = 0;
    @(posedge clk); #1;
    instr = i;
    instr_valid = 1'b1;
    for (int k = 0; k < 8 && !got; k++) begin
      if (instr_ready) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("accept", int'(got), 1);
    if (!got) begin
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 12'($urandom);
`ifdef ALU_SEQ_DBG_EN
    dbg_addr = 2'($urandom);
`endif
    @(negedge clk);
    @(negedge clk);
    dn = int'(done); e = int'(err); d = int'(wb_data); r = int'(wb_rd);
    @(negedge clk);
    z = int'(zero_flag);
  endtask

  int d, r, e, dn, z, acc;

  initial begin
    // Reset values while held in reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_wb_rd", int'(wb_rd), 0);
    chk("rst_wb_data", int'(wb_data), 0);
    chk("rst_zero", int'(zero_flag), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", int'(instr_ready), 1);

    // LDI r1,12; LDI r2,10; AND r3,r1,r2 (reserved bits set, must be ignored)
    run(mk(5, 1, 3, 0), d, r, e, dn, z);
    chk("ldi12_data", d, 12);
    run(mk(5, 2, 2, 2), d, r, e, dn, z);
    chk("ldi10_data", d, 10);
    run(mk(0, 3, 1, 2) | 12'h007, d, r, e, dn, z);
    chk("and_done", dn, 1); chk("and_rd", r, 3); chk("and_data", d, 8); chk("and_zero", z, 0);

    // OR then ADD with wrap
    run(mk(1, 0, 1, 2), d, r, e, dn, z);
    chk("or_data", d, 14);
    run(mk(2, 0, 1, 2), d, r, e, dn, z);
    chk("add_data", d, 6); chk("add_zero", z, 0);

    // SUB to zero, then NOT clears the flag
    run(mk(3, 3, 1, 1), d, r, e, dn, z);
    chk("sub_data", d, 0); chk("sub_zero", z, 1);
    run(mk(4, 2, 1, 0), d, r, e, dn, z);
    chk("not_data", d, 3); chk("not_zero", z, 0);

    // Illegal op after zero_flag=1
    run(mk(3, 3, 1, 1), d, r, e, dn, z);
    chk("sub2_zero", z, 1);
    run(mk(6, 1, 2, 3), d, r, e, dn, z);
    chk("ill_err", e, 1); chk("ill_done", dn, 1); chk("ill_data", d, 0); chk("ill_zero", z, 1);

    // instr_valid held high for 9 cycles
    @(posedge clk); #1;
    instr_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 9; c++) begin
      instr = mk(5, int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                 int'($urandom_range(3, 0)));
      chk("ready_pattern", int'(instr_ready), int'(c % 3 == 0));
      if (instr_ready) acc++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    chk("accept_count", acc, 3);

    // Reset in EXEC of LDI r1,5: rewrite r1=12 first so a surviving write is visible
    run(mk(5, 1, 3, 0), d, r, e, dn, z);
    @(posedge clk); #1;
    instr = mk(5, 1, 1, 1);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst_n = 1'b0;
`ifdef ALU_SEQ_DBG_EN
    dbg_addr = 2'd1;
`endif
    @(negedge clk);
    chk("abort_done", int'(done), 0);
    chk("abort_ready", int'(instr_ready), 1);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready_rel", int'(instr_ready), 1);
    chk("abort_wb_data", int'(wb_data), 0);
`ifdef ALU_SEQ_DBG_EN
    chk("abort_r1", int'(dbg_data), 0);
`endif
    repeat (3) @(negedge clk);

    // Random traffic, including one mid-stream reset
    for (int k = 0; k < 800; k++) begin
      @(posedge clk); #1;
      instr_valid = ($urandom_range(3, 0) != 0);
      instr = 12'($urandom);
`ifdef ALU_SEQ_DBG_EN
      dbg_addr = 2'($urandom);
`endif
      rst_n = !(k == 400 || k == 401);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
